// File: rtl/run_monitor_pkg.sv
// ============================================================================
// run_monitor_pkg : state and fail-code types shared by RTL, bench and LEDs.
// Revision: 1.0
// ============================================================================
`default_nettype none

package run_monitor_pkg;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } run_state_e;

   typedef enum logic [1:0] {
      FC_NONE      = 2'd0,
      FC_NO_RETIRE = 2'd1,
      FC_STALL     = 2'd2,
      FC_TIMEOUT   = 2'd3
   } fail_code_e;

endpackage

`default_nettype wire

// File: rtl/run_monitor_if.sv
// ============================================================================
// run_monitor_if : retirement stream from the core to the run monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface run_monitor_if #(
   parameter int PC_W = 32
) ();
   logic            insn_vld;
   logic [PC_W-1:0] pc;

   modport master (output insn_vld, output pc);
   modport slave  (input  insn_vld, input  pc);
endinterface

`default_nettype wire

// File: rtl/run_monitor_sat_cnt.sv
// ============================================================================
// run_monitor_sat_cnt : up-counter with synchronous clear, sticks at all-ones.
// Revision: 1.0
// ============================================================================
`default_nettype none

module run_monitor_sat_cnt #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/run_monitor.sv
// ============================================================================
// run_monitor : core reset sequencer plus sticky PASS/FAIL health verdict.
// Optional macro RUN_MON_SIG_EN adds the o_pc_sig retirement signature.
// Revision: 1.0
// ============================================================================
`default_nettype none

module run_monitor
   import run_monitor_pkg::*;
#(
   parameter int RST_HOLD_CYC  = 4,
   parameter int MAX_CYC       = 2000,
   parameter int STALL_LIMIT   = 256,
   parameter int HEARTBEAT_CYC = 100,
   parameter int STOP_MODE     = 0,
   parameter int PC_W          = 32,
   parameter int CNT_W         = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   run_monitor_if.slave     ret_if,
`ifdef RUN_MON_SIG_EN
   output logic [PC_W-1:0]  o_pc_sig,
`endif
   output logic             o_cpu_rst_n,
   output logic             o_running,
   output logic             o_done,
   output logic             o_pass,
   output logic [1:0]       o_fail_code,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic [CNT_W-1:0] o_retired_cnt,
   output logic             o_heartbeat
);

   localparam int HOLD_W = (RST_HOLD_CYC > 1) ? $clog2(RST_HOLD_CYC) : 1;
   localparam int HB_W   = (HEARTBEAT_CYC > 1) ? $clog2(HEARTBEAT_CYC) : 1;

   localparam logic [HOLD_W-1:0] C_HOLD_LAST  = HOLD_W'(RST_HOLD_CYC - 1);
   localparam logic [HB_W-1:0]   C_HB_LAST    = HB_W'(HEARTBEAT_CYC - 1);
   localparam logic [CNT_W-1:0]  C_MAX_LAST   = CNT_W'(MAX_CYC - 1);
   localparam logic [CNT_W-1:0]  C_STALL_LAST = CNT_W'(STALL_LIMIT - 1);

   run_state_e        state_q,     state_d;
   fail_code_e        code_q,      code_d;
   logic [HOLD_W-1:0] hold_q,      hold_d;
   logic [HB_W-1:0]   hb_cnt_q,    hb_cnt_d;
   logic [PC_W-1:0]   prev_pc_q,   prev_pc_d;
   logic              prev_vld_q,  prev_vld_d;
   logic              done_q,      done_d;
   logic              pass_q,      pass_d;
   logic              hb_q,        hb_d;
   logic              cpu_rst_n_q, cpu_rst_n_d;
   logic              running_q,   running_d;

   logic              run;
   logic              retire;
   logic              self_loop;
   logic              stall_hit;
   logic              timeout;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  retired_cnt;
   logic [CNT_W-1:0]  stall_cnt;

   assign run    = (state_q == RUN);
   assign retire = run && ret_if.insn_vld;

   run_monitor_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (1'b0),
      .i_inc (run),
      .o_cnt (cycle_cnt)
   );

   run_monitor_sat_cnt #(.W(CNT_W)) u_retire_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (1'b0),
      .i_inc (retire),
      .o_cnt (retired_cnt)
   );

   run_monitor_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_clr (retire),
      .i_inc (run && !ret_if.insn_vld),
      .o_cnt (stall_cnt)
   );

   // The stall limit is judged on the idle count accumulated before this
   // cycle, so a retirement landing on the limit cycle still counts as a hit
   // and the self-loop priority decides between the two.
   assign stall_hit = (stall_cnt == C_STALL_LAST);
   assign timeout   = (cycle_cnt == C_MAX_LAST);
   assign self_loop = (STOP_MODE == 1) && ret_if.insn_vld && prev_vld_q &&
                      (ret_if.pc == prev_pc_q);

   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      hold_d     = hold_q;
      hb_cnt_d   = hb_cnt_q;
      hb_d       = 1'b0;
      prev_pc_d  = prev_pc_q;
      prev_vld_d = prev_vld_q;
      done_d     = done_q;
      pass_d     = pass_q;

      case (state_q)
         HOLD: begin
            if (hold_q == C_HOLD_LAST) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         RUN: begin
            if (hb_cnt_q == C_HB_LAST) begin
               hb_cnt_d = '0;
               hb_d     = 1'b1;
            end else begin
               hb_cnt_d = hb_cnt_q + 1'b1;
            end
            if (ret_if.insn_vld) begin
               prev_pc_d  = ret_if.pc;
               prev_vld_d = 1'b1;
            end
            if (self_loop) begin
               state_d = PASS;
               done_d  = 1'b1;
               pass_d  = 1'b1;
            end else if (stall_hit) begin
               state_d = FAIL;
               done_d  = 1'b1;
               code_d  = FC_STALL;
            end else if (timeout) begin
               done_d = 1'b1;
               if (STOP_MODE == 0) begin
                  if ((retired_cnt != '0) || ret_if.insn_vld) begin
                     state_d = PASS;
                     pass_d  = 1'b1;
                  end else begin
                     state_d = FAIL;
                     code_d  = FC_NO_RETIRE;
                  end
               end else begin
                  state_d = FAIL;
                  code_d  = FC_TIMEOUT;
               end
            end
         end
         default: begin
         end
      endcase

      // Terminal states drop the core back into reset to freeze it.
      cpu_rst_n_d = (state_d == RUN);
      running_d   = (state_d == RUN);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= HOLD;
         code_q      <= FC_NONE;
         hold_q      <= '0;
         hb_cnt_q    <= '0;
         hb_q        <= 1'b0;
         prev_pc_q   <= '0;
         prev_vld_q  <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         cpu_rst_n_q <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         hold_q      <= hold_d;
         hb_cnt_q    <= hb_cnt_d;
         hb_q        <= hb_d;
         prev_pc_q   <= prev_pc_d;
         prev_vld_q  <= prev_vld_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         cpu_rst_n_q <= cpu_rst_n_d;
         running_q   <= running_d;
      end
   end

`ifdef RUN_MON_SIG_EN
   logic [PC_W-1:0] sig_q;
   logic [PC_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (retire) begin
         sig_d = {sig_q[PC_W-2:0], sig_q[PC_W-1]} ^ ret_if.pc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign o_pc_sig = sig_q;
`endif

   assign o_cpu_rst_n   = cpu_rst_n_q;
   assign o_running     = running_q;
   assign o_done        = done_q;
   assign o_pass        = pass_q;
   assign o_fail_code   = code_q;
   assign o_cycle_cnt   = cycle_cnt;
   assign o_retired_cnt = retired_cnt;
   assign o_heartbeat   = hb_q;

endmodule

`default_nettype wire

// File: tb/tb_run_monitor.sv
// ============================================================================
// tb_run_monitor : directed self-checking bench for run_monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_run_monitor;
   import run_monitor_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b1;
   logic rst_c = 1'b1;
   logic rst_e = 1'b1;

   run_monitor_if #(.PC_W(32)) if_a ();
   run_monitor_if #(.PC_W(32)) if_c ();
   run_monitor_if #(.PC_W(32)) if_e ();

   logic        a_cpu, a_run, a_done, a_pass, a_hb;
   logic [1:0]  a_code;
   logic [31:0] a_cyc, a_ret;
   logic        c_cpu, c_run, c_done, c_pass, c_hb;
   logic [1:0]  c_code;
   logic [31:0] c_cyc, c_ret;
   logic        e_cpu, e_run, e_done, e_pass, e_hb;
   logic [1:0]  e_code;
   logic [31:0] e_cyc, e_ret;
`ifdef RUN_MON_SIG_EN
   logic [31:0] a_sig, c_sig, e_sig;
`endif

   // Stall limit above the cycle budget so the timeout path is reachable.
   run_monitor #(.STALL_LIMIT(4096)) dut_a (
      .i_clk(clk), .i_rst(rst_a), .ret_if(if_a),
`ifdef RUN_MON_SIG_EN
      .o_pc_sig(a_sig),
`endif
      .o_cpu_rst_n(a_cpu), .o_running(a_run), .o_done(a_done), .o_pass(a_pass),
      .o_fail_code(a_code), .o_cycle_cnt(a_cyc), .o_retired_cnt(a_ret),
      .o_heartbeat(a_hb)
   );

   run_monitor #(.STALL_LIMIT(8)) dut_c (
      .i_clk(clk), .i_rst(rst_c), .ret_if(if_c),
`ifdef RUN_MON_SIG_EN
      .o_pc_sig(c_sig),
`endif
      .o_cpu_rst_n(c_cpu), .o_running(c_run), .o_done(c_done), .o_pass(c_pass),
      .o_fail_code(c_code), .o_cycle_cnt(c_cyc), .o_retired_cnt(c_ret),
      .o_heartbeat(c_hb)
   );

   run_monitor #(.STOP_MODE(1), .MAX_CYC(50), .STALL_LIMIT(8)) dut_e (
      .i_clk(clk), .i_rst(rst_e), .ret_if(if_e),
`ifdef RUN_MON_SIG_EN
      .o_pc_sig(e_sig),
`endif
      .o_cpu_rst_n(e_cpu), .o_running(e_run), .o_done(e_done), .o_pass(e_pass),
      .o_fail_code(e_code), .o_cycle_cnt(e_cyc), .o_retired_cnt(e_ret),
      .o_heartbeat(e_hb)
   );

   int vectors     = 0;
   int miscompares = 0;
   int pulses      = 0;
   int hb_bad      = 0;

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic restart_e();
      rst_e = 1'b1;
      if_e.insn_vld = 1'b0;
      step();
      rst_e = 1'b0;
      step(4);
   endtask

   initial begin
      if_a.insn_vld = 1'b0; if_a.pc = '0;
      if_c.insn_vld = 1'b0; if_c.pc = '0;
      if_e.insn_vld = 1'b0; if_e.pc = '0;

      // Reset state and hold sequence, no retirement -> NO_RETIRE at 2000
      step(2);
      chk("rst_cpu_rst_n", a_cpu, 0);
      chk("rst_running", a_run, 0);
      chk("rst_done", a_done, 0);
      chk("rst_pass", a_pass, 0);
      chk("rst_code", a_code, FC_NONE);
      chk("rst_cycle", a_cyc, 0);
      chk("rst_retired", a_ret, 0);
      chk("rst_hb", a_hb, 0);
      rst_a = 1'b0;
      step(3);
      chk("hold_cpu_rst_n_3", a_cpu, 0);
      step();
      chk("hold_cpu_rst_n_4", a_cpu, 1);
      chk("hold_running_4", a_run, 1);
      chk("hold_cycle_4", a_cyc, 0);
      step(1999);
      chk("noret_done_1999", a_done, 0);
      chk("noret_cycle_1999", a_cyc, 1999);
      step();
      chk("noret_done", a_done, 1);
      chk("noret_pass", a_pass, 0);
      chk("noret_code", a_code, FC_NO_RETIRE);
      chk("noret_cycle", a_cyc, 2000);
      chk("noret_retired", a_ret, 0);
      chk("noret_cpu_rst_n", a_cpu, 0);
      chk("noret_running", a_run, 0);
      if_a.insn_vld = 1'b1;
      step(3);
      chk("term_cycle_frozen", a_cyc, 2000);
      chk("term_retired_frozen", a_ret, 0);
      chk("term_done_sticky", a_done, 1);
      chk("term_hb", a_hb, 0);

      // Retire every cycle -> PASS at 2000 with 20 heartbeats
      if_a.insn_vld = 1'b0;
      rst_a = 1'b1;
      step();
      chk("rerst_done", a_done, 0);
      chk("rerst_cycle", a_cyc, 0);
      rst_a = 1'b0;
      step(4);
      for (int k = 1; k <= 2000; k++) begin
         if (k == 2000) begin
            chk("busy_done_1999", a_done, 0);
         end
         if_a.insn_vld = 1'b1;
         if_a.pc = 32'(k * 4);
         step();
         if (a_hb) pulses++;
         if (a_hb !== ((k % 100) == 0)) hb_bad++;
      end
      chk("busy_done", a_done, 1);
      chk("busy_pass", a_pass, 1);
      chk("busy_code", a_code, FC_NONE);
      chk("busy_cycle", a_cyc, 2000);
      chk("busy_retired", a_ret, 2000);
      chk("hb_pulses", pulses, 20);
      chk("hb_misplaced", hb_bad, 0);
      step();
      chk("busy_hb_after", a_hb, 0);
      if_a.insn_vld = 1'b0;

      // Stall: 5 retirements then idle -> FAIL STALL on 8th idle cycle
      rst_c = 1'b0;
      step(4);
      chk("stall_running", c_run, 1);
      for (int k = 0; k < 5; k++) begin
         if_c.insn_vld = 1'b1;
         if_c.pc = 32'(k * 4);
         step();
      end
      if_c.insn_vld = 1'b0;
      step(7);
      chk("stall_done_7", c_done, 0);
      step();
      chk("stall_done", c_done, 1);
      chk("stall_pass", c_pass, 0);
      chk("stall_code", c_code, FC_STALL);
      chk("stall_retired", c_ret, 5);
      chk("stall_cycle", c_cyc, 13);
      chk("stall_cpu_rst_n", c_cpu, 0);
      if_c.insn_vld = 1'b1;
      step(2);
      chk("stall_vld_ignored", c_ret, 5);
      if_c.insn_vld = 1'b0;

      // Self-loop halt: PCs 0,4,8,8
      rst_e = 1'b0;
      step(4);
      if_e.insn_vld = 1'b1;
      if_e.pc = 32'h0; step();
      if_e.pc = 32'h4; step();
      if_e.pc = 32'h8; step();
      chk("loop_done_3", e_done, 0);
      if_e.pc = 32'h8; step();
      chk("loop_done", e_done, 1);
      chk("loop_pass", e_pass, 1);
      chk("loop_code", e_code, FC_NONE);
      chk("loop_retired", e_ret, 4);

      // Self-loop and stall hit on the same cycle -> PASS
      restart_e();
      for (int k = 1; k <= 41; k++) begin
         if_e.insn_vld = 1'b1;
         if_e.pc = 32'(k * 4);
         step();
      end
      if_e.insn_vld = 1'b0;
      step(7);
      chk("prio_done_48", e_done, 0);
      if_e.insn_vld = 1'b1;
      if_e.pc = 32'hA4;
      step();
      chk("prio_done", e_done, 1);
      chk("prio_pass", e_pass, 1);
      chk("prio_code", e_code, FC_NONE);
      chk("prio_cycle", e_cyc, 49);
      chk("prio_retired", e_ret, 42);

      // STOP_MODE=1 timeout -> FAIL TIMEOUT
      restart_e();
      for (int k = 1; k <= 49; k++) begin
         if_e.insn_vld = 1'b1;
         if_e.pc = 32'(k * 4);
         step();
      end
      chk("tmo_done_49", e_done, 0);
      if_e.pc = 32'd200;
      step();
      chk("tmo_done", e_done, 1);
      chk("tmo_pass", e_pass, 0);
      chk("tmo_code", e_code, FC_TIMEOUT);
      chk("tmo_cycle", e_cyc, 50);

      // Mid-RUN reset at cycle 30 replays hold and forgets the previous PC
      restart_e();
      for (int k = 1; k <= 30; k++) begin
         if_e.insn_vld = 1'b1;
         if_e.pc = 32'h100 + 32'(k * 4);
         step();
      end
      chk("mid_cycle_30", e_cyc, 30);
      rst_e = 1'b1;
      if_e.pc = 32'h178;
      step();
      chk("mid_running", e_run, 0);
      chk("mid_cpu_rst_n", e_cpu, 0);
      chk("mid_cycle", e_cyc, 0);
      chk("mid_retired", e_ret, 0);
      rst_e = 1'b0;
      step(3);
      chk("mid_hold_cpu_rst_n", e_cpu, 0);
      chk("mid_hold_vld_ignored", e_ret, 0);
      step();
      chk("mid_replay_cpu_rst_n", e_cpu, 1);
      step();
      chk("mid_prev_cleared", e_done, 0);
      chk("mid_retired_1", e_ret, 1);
      step();
      chk("mid_loop_pass", e_pass, 1);
      chk("mid_retired_2", e_ret, 2);

`ifdef RUN_MON_SIG_EN
      rst_e = 1'b1;
      if_e.insn_vld = 1'b0;
      step();
      chk("sig_rst", e_sig, 0);
      rst_e = 1'b0;
      step(4);
      if_e.insn_vld = 1'b1;
      if_e.pc = 32'h4; step();
      chk("sig_after_4", e_sig, 32'h4);
      if_e.pc = 32'h8; step();
      chk("sig_after_8", e_sig, 32'h0);
`endif
      if_e.insn_vld = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/run_monitor.md
Name: run_monitor

Overview:
- Synthesizable run-control and health monitor for the singlecycle core.
- Holds the core in reset for a programmable interval, then releases it.
- Watches retirement (insn_vld/PC) and renders a sticky PASS/FAIL verdict with a fail code.
- Sits between the top-level clock/reset and the core; used in the bench and on the FPGA, with the verdict mirrored to LEDs.

Parameters:
- RST_HOLD_CYC, 4: cycles the core's reset is held after i_rst deasserts.
- MAX_CYC, 2000: RUN-phase cycle budget.
- STALL_LIMIT, 256: consecutive RUN cycles without retirement before a stall failure.
- HEARTBEAT_CYC, 100: period of the o_heartbeat pulse.
- STOP_MODE, 0:
  - 0: at timeout, PASS if any instruction retired.
  - 1: PASS requires self-loop halt detection; timeout is a FAIL.
- PC_W, 32: PC width.
- CNT_W, 32: width of the cycle and retire counters.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: synchronous, active-high reset.
- i_insn_vld, input, 1: core retired an instruction this cycle.
- i_pc, input, PC_W: core PC, sampled when i_insn_vld is high.
- o_cpu_rst_n, output, 1: active-low reset to the core.
- o_running, output, 1: state is RUN.
- o_done, output, 1: verdict reached (sticky).
- o_pass, output, 1: verdict is PASS (sticky).
- o_fail_code, output, 2: 0 NONE, 1 NO_RETIRE, 2 STALL, 3 TIMEOUT.
- o_cycle_cnt, output, CNT_W: RUN cycles elapsed.
- o_retired_cnt, output, CNT_W: instructions retired.
- o_heartbeat, output, 1: one-cycle pulse every HEARTBEAT_CYC RUN cycles.

Behaviour:
- Reset (i_rst=1, sampled at the clock edge):
  - state=HOLD; all counters=0; prev-PC valid flag cleared.
  - Outputs: o_cpu_rst_n=0, o_running=0, o_done=0, o_pass=0, o_fail_code=0, o_heartbeat=0.
  - Asserting i_rst in any state, including mid-RUN or in a terminal state, returns to HOLD on the next edge.
- Outputs are registered. States: HOLD, RUN, PASS, FAIL.
- HOLD:
  - hold_cnt increments each cycle with i_rst=0.
  - When hold_cnt==RST_HOLD_CYC-1: go to RUN and set o_cpu_rst_n=1 on the same edge.
  - Result: the core sees reset for exactly RST_HOLD_CYC cycles after i_rst falls.
- RUN, every cycle:
  - cycle_cnt increments.
  - retired_cnt increments when i_insn_vld=1.
  - Both counters saturate at all-ones; they never wrap.
- Stall counter:
  - Cleared when i_insn_vld=1; otherwise incremented.
  - Reaching STALL_LIMIT sets stall_hit.
- Self-loop detection:
  - Fires when i_insn_vld=1, prev-PC is valid, and i_pc==prev_pc.
  - prev_pc is updated on every i_insn_vld.
  - Detection is active only when STOP_MODE=1.
- Timeout fires when cycle_cnt==MAX_CYC-1 (the counter increment of that cycle still lands).
- Verdict priority within one cycle, highest first:
  - self-loop → PASS.
  - stall_hit → FAIL, code STALL.
  - timeout with STOP_MODE=0: retired_cnt>0 or i_insn_vld this cycle → PASS; otherwise FAIL, code NO_RETIRE.
  - timeout with STOP_MODE=1 → FAIL, code TIMEOUT.
- Heartbeat:
  - Separate counter, wraps at HEARTBEAT_CYC.
  - Pulses on the wrap cycle; first pulse on the HEARTBEAT_CYC-th RUN cycle.
  - Held at 0 outside RUN.
- PASS and FAIL are terminal:
  - o_done=1; o_cpu_rst_n=0, which freezes the core.
  - Counters frozen; o_heartbeat=0.
  - Exit only via i_rst.
- i_insn_vld is ignored outside RUN.

Optional Feature:
- Macro: RUN_MON_SIG_EN.
- Defined:
  - Adds output o_pc_sig[PC_W-1:0], reset to 0.
  - On each RUN retirement: o_pc_sig <= {o_pc_sig[PC_W-2:0], o_pc_sig[PC_W-1]} ^ i_pc.
  - Frozen in terminal states; gives a per-program signature for regression.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package run_monitor_pkg:
  - state enum run_state_e {HOLD, RUN, PASS, FAIL}.
  - fail code enum fail_code_e {FC_NONE, FC_NO_RETIRE, FC_STALL, FC_TIMEOUT}.
  - Shared by the RTL, the bench and the LED mapping.
- One sub-module run_monitor_sat_cnt:
  - Parametrised width; inputs clr and inc; saturating.
  - Instantiated for the cycle, retire and stall counters.

Test Plan:
- Default parameters; drop i_rst; never assert i_insn_vld → o_cpu_rst_n rises after exactly 4 cycles. At RUN cycle 2000: o_done=1, o_pass=0, o_fail_code=1, o_cycle_cnt=2000, o_retired_cnt=0. (With the default STALL_LIMIT=256 the stall check fires first, at RUN cycle 256, with o_fail_code=2; this scenario therefore runs with STALL_LIMIT set above MAX_CYC.)
- STOP_MODE=0; i_insn_vld=1 every cycle with an incrementing PC → PASS at cycle 2000, o_retired_cnt=2000, heartbeat pulses at RUN cycles 100, 200, … (20 pulses total).
- STALL_LIMIT=8; retire 5 instructions, then hold i_insn_vld=0 → FAIL code 2 on the 8th idle cycle; o_retired_cnt=5; o_cpu_rst_n=0.
- STOP_MODE=1; retire PCs 0x0, 0x4, 0x8, 0x8 → PASS on the second 0x8; o_retired_cnt=4.
- STOP_MODE=1, MAX_CYC=50, STALL_LIMIT=8; self-loop retirement and stall_hit both land on cycle 49 → PASS. Separately, assert i_rst mid-RUN at cycle 30 → HOLD, counters 0, reset sequence replays.
- With RUN_MON_SIG_EN defined; retire PCs 0x4, 0x8 → o_pc_sig=0x4, then 0x8^0x8=0x0.
